can_bit_timing: RTL
===================

// Module: can_bit_timing
// PURPOSE
// CAN bit-timing controller. Divides the system clock into time quanta (tq) and sequences each
// bit time through SYNC/SEG1/SEG2. Issues the sample-point strobe SP and the sampled bit that feed
// the bit-destuffing and frame-decoding datapath. Realigns to RX via hard sync and via resync
// limited by SJW.
// PARAMETERS
// PRESCALER  4  clock cycles per tq (>=1)
// TSEG1      7  tq in SEG1 = prop + phase1 (>=2)
// TSEG2      2  tq in SEG2 = phase2 (>=SJW, >=1)
// SJW        1  resync jump width in tq (>=1)
// PORTS
// clock        in   1  system clock, all logic rising-edge
// reset        in   1  synchronous reset, active-low
// enable       in   1  bus integration enable; 0 forces IDLE
// RX           in   1  raw CAN bus input (1 = recessive)
// hard_sync_en in   1  from frame decoder: bus idle/intermission, next falling edge hard-syncs
// SP           out  1  one-cycle pulse at sample point
// sampled_bit  out  1  bit value captured at last sample point
// bit_start    out  1  one-cycle pulse, first clock of SYNC
// hard_synced  out  1  one-cycle pulse when a hard sync is taken
// BEHAVIOUR
// - Reset (reset==0 at clock edge): state=IDLE, presc=0, seg_cnt=0, ext=shr=0, synced_flag=0,
//   RX sync flops=1, SP=0, bit_start=0, hard_synced=0, sampled_bit=1. Reset wins over all else.
// - RX sync: 2-flop synchronizer -> rx_s; rx_q = rx_s delayed 1 clock.
//   edge = rx_q==1 && rx_s==0 (recessive->dominant only).
// - FSM states: IDLE, SYNC, SEG1, SEG2. Segment lengths: SYNC=1, SEG1=TSEG1+ext, SEG2=TSEG2-shr tq.
// - presc counts 0..PRESCALER-1 each clock; tq boundary when presc==PRESCALER-1.
//   seg_cnt counts tq within the segment; at the boundary of a segment's last tq -> next state,
//   seg_cnt=0. SEG2 end -> SYNC; ext, shr and synced_flag clear on entering SYNC.
// - IDLE: counters held at 0. Any edge -> hard sync (regardless of hard_sync_en).
// - Hard sync (IDLE, or edge && hard_sync_en, in any state): next clock state=SYNC, presc=0,
//   seg_cnt=0, ext=shr=0; hard_synced=1 and bit_start=1 that clock. Takes priority over resync.
// - Resync (edge && !hard_sync_en && !synced_flag, state!=IDLE), sets synced_flag:
//   - in SYNC: no action.
//   - in SEG1 at seg_cnt=k: ext=min(k+1,SJW).
//   - in SEG2 with r = SEG2_len - seg_cnt: if r<=SJW then next clock SYNC, presc=0
//     (bit_start=1); else shr=SJW.
// - Second edge in the same bit: ignored.
// - Sample: in the clock where state==SEG1, seg_cnt==SEG1_len-1 and presc==PRESCALER-1, rx_s is
//   captured. Next clock: SP=1 and sampled_bit=captured value.
//   SP at SYNC start + (1+TSEG1+ext)*PRESCALER clocks.
// - All outputs registered. SP, bit_start and hard_synced are never high longer than 1 clock.
// - enable==0 mid-bit: next clock IDLE, counters 0, pending SP suppressed, sampled_bit held.
//   Mid-bit reset: same, plus sampled_bit=1.
// - Nominal bit period = (1+TSEG1+TSEG2)*PRESCALER = 40 clocks at defaults.
// TESTING
// T1 reset=0 3 clocks, RX=1, enable=1 for 200 clocks -> SP=bit_start=0, sampled_bit=1.
// T2 defaults, edge detected at clock E from IDLE -> hard_synced,bit_start at E+1; SP at E+33,
//    sampled_bit=0. With RX held 0, later SPs every 40 clocks.
// T3 hard_sync_en=0, edge at SEG1 seg_cnt=1 -> ext=1; SP 36 clocks after SYNC start,
//    next bit_start 44 clocks after the previous one.
// T4 edge in first tq of SEG2 (r=2>SJW) -> shr=1, next SP 36 clocks after the previous SP.
//    Edge in last tq of SEG2 -> SYNC next clock.
// T5 two edges in one bit, or an edge in SYNC -> no change to the 40-clock SP spacing.
// T6 enable or reset dropped 5 clocks before the expected SP -> no SP. Re-enable + edge ->
//    timing restarts per T2.

Source files
------------

// File: rtl/can_bit_timing.sv
// rtl/can_bit_timing.sv - CAN bit-timing controller: tq prescaler, SYNC/SEG1/SEG2 sequencing, hard sync and SJW-limited resync
module can_bit_timing #(
  parameter int PRESCALER = 4,
  parameter int TSEG1     = 7,
  parameter int TSEG2     = 2,
  parameter int SJW       = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic RX,
  input  logic hard_sync_en,
  output logic SP,
  output logic sampled_bit,
  output logic bit_start,
  output logic hard_synced
);

  localparam int PRESC_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int SEG_W   = $clog2(TSEG1 + SJW + TSEG2 + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALER - 1);
  localparam logic [SEG_W-1:0]   TSEG1_C    = SEG_W'(TSEG1);
  localparam logic [SEG_W-1:0]   TSEG2_C    = SEG_W'(TSEG2);
  localparam logic [SEG_W-1:0]   SJW_C      = SEG_W'(SJW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEG1,
    ST_SEG2
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEG_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic [SEG_W-1:0]   ext_q, ext_d;
  logic [SEG_W-1:0]   shr_q, shr_d;
  logic               synced_q, synced_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rx_s_q, rx_s_d;
  logic               rx_dly_q, rx_dly_d;
  logic               sp_q, sp_d;
  logic               sampled_bit_q, sampled_bit_d;
  logic               bit_start_q, bit_start_d;
  logic               hard_synced_q, hard_synced_d;

  logic               fall_edge;
  logic               tq_end;
  logic               go_sync;
  logic [SEG_W-1:0]   seg1_len;
  logic [SEG_W-1:0]   seg2_len;
  logic [SEG_W-1:0]   seg2_left;

  always_comb begin
    rx_meta_d     = RX;
    rx_s_d        = rx_meta_q;
    rx_dly_d      = rx_s_q;
    fall_edge     = rx_dly_q & ~rx_s_q;
    tq_end        = (presc_q == PRESC_LAST);

    state_d       = state_q;
    presc_d       = tq_end ? '0 : presc_q + 1'b1;
    seg_cnt_d     = seg_cnt_q;
    ext_d         = ext_q;
    shr_d         = shr_q;
    synced_d      = synced_q;
    sp_d          = 1'b0;
    sampled_bit_d = sampled_bit_q;
    bit_start_d   = 1'b0;
    hard_synced_d = 1'b0;
    go_sync       = 1'b0;
    seg2_left     = (TSEG2_C - shr_q) - seg_cnt_q;
    seg1_len      = TSEG1_C + ext_q;
    seg2_len      = TSEG2_C - shr_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      presc_d   = '0;
      seg_cnt_d = '0;
      ext_d     = '0;
      shr_d     = '0;
      synced_d  = 1'b0;
    end else if (fall_edge && (state_q == ST_IDLE || hard_sync_en)) begin
      go_sync       = 1'b1;
      hard_synced_d = 1'b1;
    end else if (state_q == ST_IDLE) begin
      presc_d   = '0;
      seg_cnt_d = '0;
    end else begin
      if (fall_edge && !synced_q) begin
        synced_d = 1'b1;
        if (state_q == ST_SEG1) begin
          ext_d = (seg_cnt_q >= SJW_C) ? SJW_C : seg_cnt_q + 1'b1;
        end else if (state_q == ST_SEG2) begin
          if (seg2_left <= SJW_C) begin
            go_sync = 1'b1;
          end else begin
            shr_d = SJW_C;
          end
        end
      end

      // Segment ends honour a jump taken on this very clock.
      seg1_len = TSEG1_C + ext_d;
      seg2_len = TSEG2_C - shr_d;

      if (!go_sync && tq_end) begin
        case (state_q)
          ST_SYNC: begin
            state_d   = ST_SEG1;
            seg_cnt_d = '0;
          end
          ST_SEG1: begin
            if (seg_cnt_q >= seg1_len - 1'b1) begin
              state_d       = ST_SEG2;
              seg_cnt_d     = '0;
              sp_d          = 1'b1;
              sampled_bit_d = rx_s_q;
            end else begin
              seg_cnt_d = seg_cnt_q + 1'b1;
            end
          end
          ST_SEG2: begin
            if (seg_cnt_q >= seg2_len - 1'b1) begin
              go_sync = 1'b1;
            end else begin
              seg_cnt_d = seg_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    if (go_sync) begin
      state_d     = ST_SYNC;
      presc_d     = '0;
      seg_cnt_d   = '0;
      ext_d       = '0;
      shr_d       = '0;
      synced_d    = 1'b0;
      bit_start_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      seg_cnt_q     <= '0;
      ext_q         <= '0;
      shr_q         <= '0;
      synced_q      <= 1'b0;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_dly_q      <= 1'b1;
      sp_q          <= 1'b0;
      sampled_bit_q <= 1'b1;
      bit_start_q   <= 1'b0;
      hard_synced_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      seg_cnt_q     <= seg_cnt_d;
      ext_q         <= ext_d;
      shr_q         <= shr_d;
      synced_q      <= synced_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      rx_dly_q      <= rx_dly_d;
      sp_q          <= sp_d;
      sampled_bit_q <= sampled_bit_d;
      bit_start_q   <= bit_start_d;
      hard_synced_q <= hard_synced_d;
    end
  end

  assign SP          = sp_q;
  assign sampled_bit = sampled_bit_q;
  assign bit_start   = bit_start_q;
  assign hard_synced = hard_synced_q;

endmodule
